// File: rtl/cell_particle_streamer_if.sv
// Downstream particle stream: {posz,posy,posx} word plus its cache address,
// qualified by a valid/ready handshake and a last marker on particle N.
interface cell_particle_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) ();
    logic [3*DATA_WIDTH-1:0] out_particle_data;
    logic [ADDR_WIDTH-1:0]   out_particle_id;
    logic                    out_valid;
    logic                    in_ready;
    logic                    out_last;

    modport master (
        output out_particle_data,
        output out_particle_id,
        output out_valid,
        output out_last,
        input  in_ready
    );

    modport slave (
        input  out_particle_data,
        input  out_particle_id,
        input  out_valid,
        input  out_last,
        output in_ready
    );
endinterface

// File: rtl/cell_particle_streamer.sv
// Read-side sequencer for one double-buffered position cache cell.
// Reads the particle count at address 0, then reads addresses 1..N and
// streams them downstream. A 2-entry skid FIFO with a bypass path absorbs
// the cache's 1-cycle read latency, so a read is only issued while the FIFO
// plus the in-flight read leave room for its data.
// Optional feature: define CLAMP_PARTICLE_COUNT_EN to clamp N to PARTICLE_NUM
// and expose the sticky out_count_clamped status bit.
module cell_particle_streamer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_start,
    input  logic                    in_motion_update,
    output logic [ADDR_WIDTH-1:0]   out_read_address,
    output logic                    out_rden,
    input  logic [3*DATA_WIDTH-1:0] in_particle_info,
    cell_particle_streamer_if.master strm,
    output logic                    out_busy,
    output logic                    out_done,
    output logic                    out_aborted
`ifdef CLAMP_PARTICLE_COUNT_EN
    ,
    output logic                    out_count_clamped
`endif
);
    localparam int PW = 3*DATA_WIDTH;
    localparam int EW = ADDR_WIDTH + PW;
    localparam logic [ADDR_WIDTH-1:0] PNUM = ADDR_WIDTH'(PARTICLE_NUM);
`ifdef CLAMP_PARTICLE_COUNT_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] n_q, n_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            fifo_count_q, fifo_count_d;
    logic                  fifo_head_q, fifo_head_d;
    logic [EW-1:0]         fifo_mem_q [2];
    logic [EW-1:0]         fifo_mem_d [2];
    logic                  aborted_q, aborted_d;
`ifdef CLAMP_PARTICLE_COUNT_EN
    logic                  clamped_q, clamped_d;
`endif

    logic [ADDR_WIDTH-1:0] cnt_raw, n_eff;
    logic                  over_limit, busy_state, abort, credit;
    logic                  head_valid, pop, fifo_pop, push, valid;
    logic [EW-1:0]         head_entry;

    // State, pointers and skid FIFO storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            n_q           <= '0;
            rd_ptr_q      <= '0;
            rd_addr_q     <= '0;
            inflight_q    <= 1'b0;
            fifo_count_q  <= '0;
            fifo_head_q   <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            aborted_q     <= 1'b0;
`ifdef CLAMP_PARTICLE_COUNT_EN
            clamped_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_addr_q     <= rd_addr_d;
            inflight_q    <= inflight_d;
            fifo_count_q  <= fifo_count_d;
            fifo_head_q   <= fifo_head_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            aborted_q     <= aborted_d;
`ifdef CLAMP_PARTICLE_COUNT_EN
            clamped_q     <= clamped_d;
`endif
        end
    end

    // Next-state, read issue, FIFO push/pop (with bypass) and abort handling.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        rd_ptr_d     = rd_ptr_q;
        rd_addr_d    = rd_addr_q;
        inflight_d   = 1'b0;
        fifo_mem_d   = fifo_mem_q;
        aborted_d    = aborted_q;
`ifdef CLAMP_PARTICLE_COUNT_EN
        clamped_d    = clamped_q;
`endif
        out_rden     = 1'b0;
        out_done     = 1'b0;

        cnt_raw    = in_particle_info[ADDR_WIDTH-1:0];
        over_limit = cnt_raw > PNUM;
        n_eff      = (CLAMP_EN && over_limit) ? PNUM : cnt_raw;

        busy_state = (state_q == RD_CNT) || (state_q == WAIT_CNT) ||
                     (state_q == STREAM) || (state_q == DRAIN);
        abort      = busy_state && in_motion_update;
        credit     = ({1'b0, fifo_count_q} + {2'b00, inflight_q}) < 3'd2;

        // Arriving data goes straight to the output when the FIFO is empty.
        head_valid = (fifo_count_q != 2'd0) || inflight_q;
        head_entry = (fifo_count_q != 2'd0) ? fifo_mem_q[fifo_head_q]
                                            : {rd_addr_q, in_particle_info};
        valid      = head_valid && !abort;
        pop        = valid && strm.in_ready;
        fifo_pop   = pop && (fifo_count_q != 2'd0);
        push       = inflight_q && !abort && !(pop && (fifo_count_q == 2'd0));
        if (push) begin
            fifo_mem_d[fifo_head_q ^ fifo_count_q[0]] = {rd_addr_q, in_particle_info};
        end
        fifo_count_d = fifo_count_q + 2'(push) - 2'(fifo_pop);
        fifo_head_d  = fifo_head_q ^ fifo_pop;

        case (state_q)
            IDLE: begin
                if (in_start && !in_motion_update) begin
                    state_d   = RD_CNT;
                    aborted_d = 1'b0;
`ifdef CLAMP_PARTICLE_COUNT_EN
                    clamped_d = 1'b0;
`endif
                end
            end
            RD_CNT: begin
                out_rden  = 1'b1;
                rd_addr_d = '0;
                state_d   = WAIT_CNT;
            end
            WAIT_CNT: begin
                n_d      = n_eff;
                rd_ptr_d = ADDR_WIDTH'(1);
`ifdef CLAMP_PARTICLE_COUNT_EN
                clamped_d = over_limit;
`endif
                state_d  = (n_eff == '0) ? DONE : STREAM;
            end
            STREAM: begin
                if (credit) begin
                    out_rden   = 1'b1;
                    rd_addr_d  = rd_ptr_q;
                    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
                    inflight_d = 1'b1;
                    if (rd_ptr_q == n_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_count_d == 2'd0) state_d = DONE;
            end
            DONE: begin
                out_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Motion update: drop everything, no reads, report next cycle.
        if (abort) begin
            state_d      = DONE;
            aborted_d    = 1'b1;
            out_rden     = 1'b0;
            rd_addr_d    = rd_addr_q;
            rd_ptr_d     = rd_ptr_q;
            n_d          = n_q;
            inflight_d   = 1'b0;
            fifo_count_d = '0;
            fifo_head_d  = 1'b0;
`ifdef CLAMP_PARTICLE_COUNT_EN
            clamped_d    = clamped_q;
`endif
        end
    end

    assign out_read_address       = rd_addr_d;
    assign out_busy               = busy_state;
    assign out_aborted            = aborted_q && (state_q == DONE);
    assign strm.out_valid         = valid;
    assign strm.out_particle_data = valid ? head_entry[PW-1:0] : '0;
    assign strm.out_particle_id   = valid ? head_entry[EW-1:PW] : '0;
    assign strm.out_last          = valid && (head_entry[EW-1:PW] == n_q);
`ifdef CLAMP_PARTICLE_COUNT_EN
    assign out_count_clamped      = clamped_q;
`endif
endmodule

// File: tb/tb_cell_particle_streamer.sv
// Bench for cell_particle_streamer: table of stream scenarios plus hand-written
// start/reset corner sequences, checked against a queue-based reference of the
// expected particle sequence read from a behavioural cache model.
module tb_cell_particle_streamer;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int PW = 3*DW;

    typedef struct {
        int count;
        int ready_mode;   // 0 always ready, 1 toggling, 2 random
        int abort_after;  // raise motion update after this many accepts, -1 never
        int exp_acc;
        int exp_first;    // cycle of first valid after start, -1 none
        int exp_done;     // cycle of done after start, -1 not checked
        bit exp_ab;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_start, in_mu;
    logic [AW-1:0] out_read_address;
    logic          out_rden;
    logic [PW-1:0] in_particle_info = '0;
    logic          out_busy, out_done, out_aborted;
`ifdef CLAMP_PARTICLE_COUNT_EN
    logic          out_count_clamped;
`endif

    cell_particle_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) strm_if ();

    cell_particle_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_start         (in_start),
        .in_motion_update (in_mu),
        .out_read_address (out_read_address),
        .out_rden         (out_rden),
        .in_particle_info (in_particle_info),
        .strm             (strm_if.master),
        .out_busy         (out_busy),
        .out_done         (out_done),
        .out_aborted      (out_aborted)
`ifdef CLAMP_PARTICLE_COUNT_EN
        ,
        .out_count_clamped(out_count_clamped)
`endif
    );

    always #5 clk = ~clk;

    logic [PW-1:0] cache [0:255];
    always @(posedge clk) if (out_rden) in_particle_info <= cache[out_read_address];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int eff_n(input int c);
        int n;
        n = c & 255;
`ifdef CLAMP_PARTICLE_COUNT_EN
        if (n > PN) n = PN;
`endif
        return n;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, strm_if.out_valid, 0);
        chk({tag, "_busy"},  out_busy, 0);
        chk({tag, "_done"},  out_done, 0);
        chk({tag, "_rden"},  out_rden, 0);
        chk({tag, "_addr"},  out_read_address, 0);
        chk({tag, "_id"},    strm_if.out_particle_id, 0);
        chk({tag, "_data"},  strm_if.out_particle_data, 0);
        chk({tag, "_last"},  strm_if.out_last, 0);
        chk({tag, "_abrt"},  out_aborted, 0);
    endtask

    task automatic load_cache(input int count);
        logic [PW-1:0] w;
        w = {$urandom, $urandom, $urandom};
        w[AW-1:0] = AW'(count);
        cache[0] = w;
        for (int i = 1; i < 256; i++) cache[i] = {$urandom, $urandom, $urandom};
    endtask

    task automatic run_stream(input vec_t v, input string tag);
        logic [AW+PW-1:0] exp_q [$];
        logic [AW+PW-1:0] e, held;
        int n, first, done_cyc, mu_cyc, last_acc, accepted, issued, max_out, budget;
        bit stalled, abort_pending, busy_bad, valid_after_abort, ab;
        load_cache(v.count);
        n = eff_n(v.count);
        for (int i = 1; i <= n; i++) exp_q.push_back({AW'(i), cache[i]});
        first = -1; done_cyc = -1; mu_cyc = -1; last_acc = -1;
        accepted = 0; issued = 0; max_out = 0; budget = 4*n + 50;
        stalled = 0; abort_pending = 0; busy_bad = 0; valid_after_abort = 0; ab = 0;
        held = '0;
        @(negedge clk);
        in_start = 1'b1;
        strm_if.in_ready = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            in_start = 1'b0;
            if (abort_pending) begin
                in_mu = 1'b1;
                mu_cyc = c;
                abort_pending = 0;
            end
            case (v.ready_mode)
                0:       strm_if.in_ready = 1'b1;
                1:       strm_if.in_ready = (c % 2) == 1;
                default: strm_if.in_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (out_done) busy_bad |= out_busy;
            else          busy_bad |= !out_busy;
            if (out_rden && out_read_address != 0) issued++;
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (strm_if.out_valid) begin
                if (first < 0) first = c;
                if (mu_cyc >= 0) valid_after_abort = 1;
                if (stalled) chk({tag, "_stall_hold"}, {strm_if.out_particle_id, strm_if.out_particle_data}, held);
                if (strm_if.in_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL %s_extra_accept: got id %0d expected no more data", tag, strm_if.out_particle_id);
                    end else begin
                        e = exp_q.pop_front();
                        chk({tag, "_id"},   strm_if.out_particle_id, e[AW+PW-1:PW]);
                        chk({tag, "_data"}, strm_if.out_particle_data, e[PW-1:0]);
                        chk({tag, "_last"}, strm_if.out_last, exp_q.size() == 0);
                    end
                    accepted++;
                    last_acc = c;
                    if (accepted == v.abort_after) abort_pending = 1;
                end
                stalled = !strm_if.in_ready;
                held = {strm_if.out_particle_id, strm_if.out_particle_data};
            end else begin
                if (stalled && mu_cyc < 0) chk({tag, "_stall_drop"}, strm_if.out_valid, 1);
                stalled = 0;
            end
            if (out_done) begin
                done_cyc = c;
                ab = out_aborted;
`ifdef CLAMP_PARTICLE_COUNT_EN
                chk({tag, "_clamped"}, out_count_clamped, (v.count & 255) > PN);
`endif
                break;
            end
        end
        chk({tag, "_done_seen"}, done_cyc >= 0, 1);
        @(negedge clk);
        in_mu = 1'b0;
        #1;
        if (done_cyc < 0) begin
            rst = 1'b1; #1; rst = 1'b0;
        end
        chk({tag, "_idle_valid"}, strm_if.out_valid, 0);
        chk({tag, "_idle_busy"}, out_busy, 0);
        chk({tag, "_accepts"}, accepted, v.exp_acc);
        chk({tag, "_aborted"}, ab, v.exp_ab);
        chk({tag, "_first"}, first, v.exp_first);
        chk({tag, "_busy"}, busy_bad, 0);
        chk({tag, "_outstanding_le2"}, max_out <= 2, 1);
        if (v.exp_done >= 0) chk({tag, "_done_cyc"}, done_cyc, v.exp_done);
        if (v.exp_ab) begin
            chk({tag, "_done_after_abort"}, done_cyc, mu_cyc + 1);
            chk({tag, "_valid_after_abort"}, valid_after_abort, 0);
        end else if (v.exp_acc > 0) begin
            chk({tag, "_done_after_last"}, done_cyc, last_acc + 1);
        end
    endtask

    vec_t vecs [10];

    initial begin
        int r;
        vecs[0] = '{5, 0, -1, 5, 4, 9, 0};
        vecs[1] = '{0, 0, -1, 0, -1, 3, 0};
        vecs[2] = '{8, 1, -1, 8, 4, -1, 0};
        vecs[3] = '{10, 0, 4, 4, 4, -1, 1};
        vecs[4] = '{1, 0, -1, 1, 4, 5, 0};
        for (int i = 5; i < 8; i++) begin
            r = int'($urandom_range(1, 40));
            vecs[i] = '{r, 2, -1, r, 4, -1, 0};
        end
        vecs[8] = '{250, 0, -1, eff_n(250), 4, 4 + eff_n(250), 0};
        vecs[9] = '{6, 2, 1, 1, 4, -1, 1};

        rst = 1'b1; in_start = 1'b0; in_mu = 1'b0; strm_if.in_ready = 1'b1;
        for (int i = 0; i < 256; i++) cache[i] = '0;
        #1;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_stream(vecs[i], $sformatf("vec%0d", i));

        // Start while motion update is active must be ignored.
        @(negedge clk);
        in_mu = 1'b1; in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("mu_block_busy", out_busy, 0);
            chk("mu_block_rden", out_rden, 0);
            @(negedge clk);
        end
        in_mu = 1'b0;

        // Start pulse in the DONE cycle must be ignored.
        load_cache(0);
        @(negedge clk);
        in_start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            in_start = 1'b0;
        end
        in_start = 1'b1;
        #1;
        chk("done_cycle_done", out_done, 1);
        @(negedge clk);
        in_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("done_start_busy", out_busy, 0);
            chk("done_start_rden", out_rden, 0);
            @(negedge clk);
        end

        // Asynchronous reset mid-stream, then a clean restart from id 1.
        load_cache(10);
        in_start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            in_start = 1'b0;
        end
        #1;
        chk("pre_rst_valid", strm_if.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        run_stream('{5, 0, -1, 5, 4, 9, 0}, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
